bip2_control_unit: RTL and testbench



---
 rtl/bip2_control_unit.sv | 144 ++++++++++++++
 tb/tb_bip2_control_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bip2_control_unit.sv
// BIP-2 multicycle control unit: fetch/decode/execute sequencer owning the PC and IR.
// Latency: LD/ADD/SUB 4 cycles, HLT 2 cycles to HALT, all other instructions 3 cycles.
// No backpressure: program memory is a fixed one-cycle synchronous read, and strobes are single-cycle pulses.
module bip2_control_unit #(
    parameter int PC_W    = 11,
    parameter int DATA_W  = 11,
    parameter int INSTR_W = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [INSTR_W-1:0] pm_data_i,
    output logic [PC_W-1:0]    pm_addr_o,
    input  logic               flagZ_i,
    input  logic               flagN_i,
    output logic [1:0]         selA_o,
    output logic               selB_o,
    output logic               wracc_o,
    output logic               op_o,
    output logic [DATA_W-1:0]  operand_o,
    output logic               dm_wr_o,
    output logic               halt_o
);

    localparam int OPC_W = INSTR_W - DATA_W;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_BNE  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_BGT  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_BGE  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_BLT  = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_BLE  = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'b01110;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEMRD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;

    logic [OPC_W-1:0]     ir_opc;
    logic [OPC_W-1:0]     pm_opc;
    logic                 branch_taken;
    logic                 acc_wr_dec;
    logic                 sto_dec;

    assign ir_opc    = ir_q[INSTR_W-1:DATA_W];
    assign pm_opc    = pm_data_i[INSTR_W-1:DATA_W];
    assign pm_addr_o = pc_q;
    assign operand_o = ir_q[DATA_W-1:0];

    // State, PC and IR registers; reset may land in any state, including mid-instruction.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Branch resolution from the live flags; the accumulator was written on an earlier EXEC edge.
    always_comb begin
        branch_taken = 1'b0;
        case (ir_opc)
            OPC_BEQ: branch_taken = flagZ_i;
            OPC_BNE: branch_taken = !flagZ_i;
            OPC_BGT: branch_taken = !flagZ_i && !flagN_i;
            OPC_BGE: branch_taken = !flagN_i;
            OPC_BLT: branch_taken = flagN_i;
            OPC_BLE: branch_taken = flagN_i || flagZ_i;
            OPC_JMP: branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state sequencing plus IR capture and PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = pm_data_i;
                case (pm_opc)
                    OPC_LD, OPC_ADD, OPC_SUB: state_d = ST_MEMRD;
                    OPC_HLT:                  state_d = ST_HALT;
                    default:                  state_d = ST_EXEC;
                endcase
            end
            ST_MEMRD: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (branch_taken) begin
                    pc_d = ir_q[PC_W-1:0];
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath controls decoded from IR; selects hold steadily, strobes are gated to EXEC.
    always_comb begin
        selA_o     = 2'b00;
        selB_o     = 1'b0;
        op_o       = 1'b0;
        acc_wr_dec = 1'b0;
        sto_dec    = 1'b0;
        case (ir_opc)
            OPC_STO:  sto_dec = 1'b1;
            OPC_LD:   begin selA_o = 2'b00; acc_wr_dec = 1'b1; end
            OPC_LDI:  begin selA_o = 2'b01; acc_wr_dec = 1'b1; end
            OPC_ADD:  begin selA_o = 2'b10; selB_o = 1'b1; acc_wr_dec = 1'b1; end
            OPC_ADDI: begin selA_o = 2'b10; selB_o = 1'b0; acc_wr_dec = 1'b1; end
            OPC_SUB:  begin selA_o = 2'b10; selB_o = 1'b1; op_o = 1'b1; acc_wr_dec = 1'b1; end
            OPC_SUBI: begin selA_o = 2'b10; selB_o = 1'b0; op_o = 1'b1; acc_wr_dec = 1'b1; end
            default:  begin end
        endcase
        wracc_o = (state_q == ST_EXEC) && acc_wr_dec;
        dm_wr_o = (state_q == ST_EXEC) && sto_dec;
        halt_o  = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Directed bench for the BIP-2 control unit with a synchronous program-memory model.
// Each scenario loads a tiny program, resets, and steps cycle by cycle checking outputs.
// Inputs driven #1 after the rising edge; outputs sampled at that same point.
module tb_bip2_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pm_data;
    logic [10:0] pm_addr;
    logic        fz, fn;
    logic [1:0]  sel_a;
    logic        sel_b, wracc, op, dm_wr, halt;
    logic [10:0] operand;

    logic [15:0] prog [0:2047];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Synchronous-read program memory: data valid the cycle after the address.
    always @(posedge clk) pm_data <= prog[pm_addr];

    bip2_control_unit dut (
        .clock_i(clk), .reset_i(rst), .pm_data_i(pm_data), .pm_addr_o(pm_addr),
        .flagZ_i(fz), .flagN_i(fn), .selA_o(sel_a), .selB_o(sel_b), .wracc_o(wracc),
        .op_o(op), .operand_o(operand), .dm_wr_o(dm_wr), .halt_o(halt)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_prog;
        for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;  // NOP
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;  // first cycle after release is FETCH
    endtask

    task automatic test_reset;
        clear_prog();
        fz = 1'b0; fn = 1'b0;
        rst = 1'b1;
        step(2);
        total++; if (pm_addr !== 11'd0) begin bad++; $display("FAIL rst_pm_addr got=%h exp=000", pm_addr); end
        total++; if (wracc !== 1'b0 || dm_wr !== 1'b0 || halt !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b%b exp=000", wracc, dm_wr, halt); end
        total++; if (sel_a !== 2'b00 || sel_b !== 1'b0 || op !== 1'b0) begin bad++; $display("FAIL rst_sels got=%b/%b/%b exp=00/0/0", sel_a, sel_b, op); end
        total++; if (operand !== 11'd0) begin bad++; $display("FAIL rst_operand got=%h exp=000", operand); end
        rst = 1'b0;
    endtask

    task automatic test_ldi_addi_hlt;
        clear_prog();
        prog[0] = {5'b00011, 11'd5};   // LDI 5
        prog[1] = {5'b00101, 11'd3};   // ADDI 3
        prog[2] = {5'b00000, 11'd0};   // HLT
        do_reset();                    // cycle 1: FETCH
        total++; if (pm_addr !== 11'd0 || wracc !== 1'b0) begin bad++; $display("FAIL c1_fetch got=%h/%b exp=000/0", pm_addr, wracc); end
        step();                        // cycle 2: DECODE
        total++; if (wracc !== 1'b0) begin bad++; $display("FAIL c2_wracc got=%b exp=0", wracc); end
        step();                        // cycle 3: EXEC LDI
        total++; if (wracc !== 1'b1 || sel_a !== 2'b01 || operand !== 11'd5) begin bad++; $display("FAIL c3_ldi got=%b/%b/%h exp=1/01/005", wracc, sel_a, operand); end
        step();                        // cycle 4: FETCH
        total++; if (wracc !== 1'b0 || pm_addr !== 11'd1) begin bad++; $display("FAIL c4_fetch got=%b/%h exp=0/001", wracc, pm_addr); end
        step(2);                       // cycle 6: EXEC ADDI
        total++; if (wracc !== 1'b1 || sel_a !== 2'b10 || sel_b !== 1'b0 || op !== 1'b0) begin bad++; $display("FAIL c6_addi got=%b/%b/%b/%b exp=1/10/0/0", wracc, sel_a, sel_b, op); end
        step();                        // cycle 7: FETCH HLT
        total++; if (pm_addr !== 11'd2 || halt !== 1'b0) begin bad++; $display("FAIL c7_fetch got=%h/%b exp=002/0", pm_addr, halt); end
        step(2);                       // HALT two cycles after the HLT fetch
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_entry got=%b exp=1", halt); end
        step(3);
        total++; if (halt !== 1'b1 || pm_addr !== 11'd2 || wracc !== 1'b0) begin bad++; $display("FAIL halt_hold got=%b/%h/%b exp=1/002/0", halt, pm_addr, wracc); end
    endtask

    task automatic test_ld;
        clear_prog();
        prog[0] = {5'b00010, 11'h010}; // LD 0x10
        do_reset();
        step(2);                       // MEMRD
        total++; if (operand !== 11'h010 || wracc !== 1'b0 || dm_wr !== 1'b0) begin bad++; $display("FAIL ld_memrd got=%h/%b/%b exp=010/0/0", operand, wracc, dm_wr); end
        step();                        // EXEC (4th cycle)
        total++; if (wracc !== 1'b1 || sel_a !== 2'b00) begin bad++; $display("FAIL ld_exec got=%b/%b exp=1/00", wracc, sel_a); end
        step();
        total++; if (pm_addr !== 11'd1 || wracc !== 1'b0) begin bad++; $display("FAIL ld_next got=%h/%b exp=001/0", pm_addr, wracc); end
    endtask

    task automatic test_branches;
        // BEQ taken
        clear_prog();
        prog[0] = {5'b00111, 11'd1};    // SUBI 1
        prog[1] = {5'b01000, 11'h7F0};  // BEQ 0x7F0
        fz = 1'b1; fn = 1'b0;
        do_reset();
        step(2);
        total++; if (wracc !== 1'b1 || sel_a !== 2'b10 || sel_b !== 1'b0 || op !== 1'b1) begin bad++; $display("FAIL subi_exec got=%b/%b/%b/%b exp=1/10/0/1", wracc, sel_a, sel_b, op); end
        step(4);
        total++; if (pm_addr !== 11'h7F0) begin bad++; $display("FAIL beq_taken got=%h exp=7f0", pm_addr); end
        // BEQ not taken
        fz = 1'b0;
        do_reset();
        step(6);
        total++; if (pm_addr !== 11'd2) begin bad++; $display("FAIL beq_not_taken got=%h exp=002", pm_addr); end
        // BLE taken on N
        clear_prog();
        prog[0] = {5'b01101, 11'h123};
        fz = 1'b0; fn = 1'b1;
        do_reset();
        step(3);
        total++; if (pm_addr !== 11'h123) begin bad++; $display("FAIL ble_taken got=%h exp=123", pm_addr); end
        // BGT not taken on N
        clear_prog();
        prog[0] = {5'b01010, 11'h055};
        do_reset();
        step(3);
        total++; if (pm_addr !== 11'd1) begin bad++; $display("FAIL bgt_not_taken got=%h exp=001", pm_addr); end
        fn = 1'b0;
    endtask

    task automatic test_sto;
        int wr_cnt, acc_cnt;
        clear_prog();
        prog[0] = {5'b00001, 11'h005};  // STO 5
        do_reset();
        wr_cnt = 0; acc_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (dm_wr === 1'b1) wr_cnt++;
            if (wracc === 1'b1) acc_cnt++;
            if (c == 2) begin
                total++; if (dm_wr !== 1'b1 || operand !== 11'h005) begin bad++; $display("FAIL sto_exec got=%b/%h exp=1/005", dm_wr, operand); end
            end
            step();
        end
        total++; if (wr_cnt != 1 || acc_cnt != 0) begin bad++; $display("FAIL sto_pulses got=%0d/%0d exp=1/0", wr_cnt, acc_cnt); end
    endtask

    task automatic test_jmp_wrap;
        int strobes;
        clear_prog();
        prog[0]     = {5'b01110, 11'h7FF};  // JMP 0x7FF
        prog[11'h7FF] = 16'hFFFF;           // NOP, opcode 11111
        do_reset();
        step(3);
        total++; if (pm_addr !== 11'h7FF) begin bad++; $display("FAIL jmp_target got=%h exp=7ff", pm_addr); end
        strobes = 0;
        for (int c = 0; c < 3; c++) begin
            if (wracc === 1'b1 || dm_wr === 1'b1 || halt === 1'b1) strobes++;
            step();
        end
        total++; if (pm_addr !== 11'h000 || strobes != 0) begin bad++; $display("FAIL pc_wrap got=%h/%0d exp=000/0", pm_addr, strobes); end
    endtask

    task automatic test_reset_mid_instr;
        clear_prog();
        prog[0] = {5'b00100, 11'h020};  // ADD 0x20
        do_reset();
        step(2);                        // MEMRD
        total++; if (operand !== 11'h020 || sel_a !== 2'b10 || sel_b !== 1'b1) begin bad++; $display("FAIL add_memrd got=%h/%b/%b exp=020/10/1", operand, sel_a, sel_b); end
        rst = 1'b1;
        step();
        total++; if (wracc !== 1'b0 || pm_addr !== 11'd0 || operand !== 11'd0 || halt !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b/%h/%h/%b exp=0/000/000/0", wracc, pm_addr, operand, halt); end
        total++; if (sel_a !== 2'b00 || sel_b !== 1'b0 || op !== 1'b0 || dm_wr !== 1'b0) begin bad++; $display("FAIL mid_rst_sels got=%b/%b/%b/%b exp=00/0/0/0", sel_a, sel_b, op, dm_wr); end
        rst = 1'b0;
        step(2);                        // restart: FETCH, DECODE of ADD again
        total++; if (wracc !== 1'b0 || pm_addr !== 11'd0) begin bad++; $display("FAIL mid_rst_restart got=%b/%h exp=0/000", wracc, pm_addr); end
    endtask

    initial begin
        rst = 1'b1; fz = 1'b0; fn = 1'b0;
        test_reset();
        test_ldi_addi_hlt();
        test_ld();
        test_branches();
        test_sto();
        test_jmp_wrap();
        test_reset_mid_instr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
